// File: rtl/enigma_flag_encoder_if.sv
// Character stream bundle for the enigma flag encoder: plaintext in, ciphertext out.
// Both sides use valid/ready: a beat transfers on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface enigma_flag_encoder_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] enc_out;
  logic       enc_valid;
  logic       enc_ready;

  modport master (
    output char_in,
    output char_valid,
    output enc_ready,
    input  char_ready,
    input  enc_out,
    input  enc_valid
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  enc_ready,
    output char_ready,
    output enc_out,
    output enc_valid
  );
endinterface

// File: rtl/enigma_flag_encoder.sv
// Rotating-shift letter encoder feeding the Bombe: ciphers each letter with (rotor + k) mod 26
// and latches the first three ciphertext letters into a packed flag word.
module enigma_flag_encoder #(
  parameter int ROTOR_MAX = 25,
  parameter int ORD_A     = 65,
  parameter int FLAG_LEN  = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [4:0]                  rotor_init_i,
  input  logic                        load_rotor_i,
  enigma_flag_encoder_if.slave        io,
  output logic                        bad_char_o,
  output logic [4:0]                  rotor_out_o,
  output logic [8*FLAG_LEN-1:0]       flag_bus_o,
  output logic                        flag_valid_o,
  output logic [1:0]                  state_o
);

  localparam logic [4:0] ROT_LAST = 5'(ROTOR_MAX);
  localparam logic [5:0] ROT_MOD  = 6'(ROTOR_MAX + 1);
  localparam logic [7:0] CHAR_LO  = 8'(ORD_A);
  localparam logic [7:0] CHAR_HI  = 8'(ORD_A + ROTOR_MAX);
  localparam logic [1:0] CNT_LAST = 2'(FLAG_LEN - 1);
  localparam logic [1:0] CNT_FULL = 2'(FLAG_LEN);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [4:0]              rotor_q, rotor_d;
  logic [1:0]              count_q, count_d;
  logic [8*FLAG_LEN-1:0]   flag_q, flag_d;
  logic [7:0]              enc_q, enc_d;
  logic                    enc_valid_q, enc_valid_d;
  logic                    bad_q, bad_d;

  logic       char_ready;
  logic       accept;
  logic       is_letter;
  logic       accept_letter;
  logic [4:0] letter_off;
  logic [5:0] shift_sum;
  logic [5:0] shift_wrap;
  logic [7:0] cipher;
  logic [5:0] init_ext;
  logic [4:0] init_mod;

  assign accept        = io.char_valid & char_ready;
  assign is_letter     = (io.char_in >= CHAR_LO) && (io.char_in <= CHAR_HI);
  assign accept_letter = accept & is_letter;

  // Both operands are below 26, so a single conditional subtract covers every wrap.
  assign letter_off = 5'(io.char_in - CHAR_LO);
  assign shift_sum  = {1'b0, letter_off} + {1'b0, rotor_q};
  assign shift_wrap = (shift_sum >= ROT_MOD) ? (shift_sum - ROT_MOD) : shift_sum;
  assign cipher     = CHAR_LO + {2'b00, shift_wrap};

  // A 5-bit setting can exceed 25 by at most 6, so one subtract reduces it.
  assign init_ext = {1'b0, rotor_init_i};
  assign init_mod = (init_ext >= ROT_MOD) ? 5'(init_ext - ROT_MOD) : rotor_init_i;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (load_rotor_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (load_rotor_i) begin
          state_d = S_RUN;
        end else if (accept_letter && (count_q == CNT_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (load_rotor_i) state_d = S_RUN;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------- state outputs
  always_comb begin
    char_ready   = 1'b0;
    flag_valid_o = 1'b0;
    state_o      = state_q;
    unique case (state_q)
      S_RUN:   char_ready   = ~load_rotor_i & (~enc_valid_q | io.enc_ready);
      S_DONE:  flag_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    rotor_d     = rotor_q;
    count_d     = count_q;
    flag_d      = flag_q;
    enc_d       = enc_q;
    enc_valid_d = enc_valid_q;
    bad_d       = accept & ~is_letter;

    if (accept_letter) begin
      enc_d       = cipher;
      enc_valid_d = 1'b1;
      rotor_d     = (rotor_q == ROT_LAST) ? 5'd0 : rotor_q + 5'd1;
      if (count_q < CNT_FULL) begin
        flag_d[{count_q, 3'b000} +: 8] = cipher;
        count_d                        = count_q + 2'd1;
      end
    end else if (io.enc_ready) begin
      enc_valid_d = 1'b0;
    end

    // A reload never touches the output register; a pending ciphertext still drains.
    if (load_rotor_i) begin
      rotor_d = init_mod;
      count_d = 2'd0;
      flag_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rotor_q     <= 5'd0;
      count_q     <= 2'd0;
      flag_q      <= '0;
      enc_q       <= 8'h00;
      enc_valid_q <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      rotor_q     <= rotor_d;
      count_q     <= count_d;
      flag_q      <= flag_d;
      enc_q       <= enc_d;
      enc_valid_q <= enc_valid_d;
      bad_q       <= bad_d;
    end
  end

  assign io.char_ready = char_ready;
  assign io.enc_out    = enc_q;
  assign io.enc_valid  = enc_valid_q;
  assign bad_char_o    = bad_q;
  assign rotor_out_o   = rotor_q;
  assign flag_bus_o    = flag_q;

endmodule

// File: tb/tb_enigma_flag_encoder.sv
// Self-checking bench for enigma_flag_encoder: directed scenarios plus random traffic,
// checked against a letter-level cipher model and an expected-ciphertext queue.
module tb_enigma_flag_encoder;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  rotor_init;
  logic        load_rotor;
  logic        bad_char;
  logic [4:0]  rotor_out;
  logic [23:0] flag_bus;
  logic        flag_valid;
  logic [1:0]  state_dbg;

  enigma_flag_encoder_if bus ();

  enigma_flag_encoder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rotor_init_i (rotor_init),
    .load_rotor_i (load_rotor),
    .io           (bus),
    .bad_char_o   (bad_char),
    .rotor_out_o  (rotor_out),
    .flag_bus_o   (flag_bus),
    .flag_valid_o (flag_valid),
    .state_o      (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for a rotor load, 1 = encrypting, 2 = flag complete.
  int         m_phase;
  int         m_rotor;
  int         m_count;
  logic [7:0] m_flag [3];
  logic       m_pend;
  logic [7:0] m_enc;
  logic       m_bad;

  task automatic model_reset();
    m_phase = 0;
    m_rotor = 0;
    m_count = 0;
    for (int i = 0; i < 3; i++) m_flag[i] = 8'h00;
    m_pend = 1'b0;
    m_enc  = 8'h00;
    m_bad  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    check("rotor_out",  32'(rotor_out),  32'(m_rotor));
    check("flag_bus",   32'(flag_bus),   32'({m_flag[2], m_flag[1], m_flag[0]}));
    check("flag_valid", 32'(flag_valid), 32'(m_phase == 2));
    check("bad_char",   32'(bad_char),   32'(m_bad));
    check("enc_valid",  32'(bus.enc_valid), 32'(m_pend));
    check("enc_out",    32'(bus.enc_out),   32'(m_enc));
  endtask

  // Monitor: every ciphertext consumed downstream must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.enc_valid && bus.enc_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL enc_stream: got %0h expected none (queue empty)", bus.enc_out);
      end else begin
        check("enc_stream", 32'(bus.enc_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick(input logic ld, input logic [4:0] rinit, input logic cv,
                      input logic [7:0] ch, input logic er);
    logic exp_rdy;
    logic acc;
    logic letter;
    logic [7:0] c;
    @(posedge clk);
    #1;
    check_outputs();
    load_rotor     = ld;
    rotor_init     = rinit;
    bus.char_valid = cv;
    bus.char_in    = ch;
    bus.enc_ready  = er;
    #1;
    exp_rdy = (m_phase == 1) && !ld && (!m_pend || er);
    check("char_ready", 32'(bus.char_ready), 32'(exp_rdy));
    acc    = cv && exp_rdy;
    letter = (ch >= 8'd65) && (ch <= 8'd90);
    m_bad  = acc && !letter;
    if (acc && letter) begin
      c = 8'(((int'(ch) - 65 + m_rotor) % 26) + 65);
      exp_q.push_back(c);
      m_enc  = c;
      m_pend = 1'b1;
      m_rotor = (m_rotor + 1) % 26;
      if (m_count < 3) begin
        m_flag[m_count] = c;
        m_count++;
        if (m_count == 3) m_phase = 2;
      end
    end else if (er) begin
      m_pend = 1'b0;
    end
    if (ld) begin
      m_rotor = int'(rinit) % 26;
      m_count = 0;
      for (int i = 0; i < 3; i++) m_flag[i] = 8'h00;
      m_phase = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    load_rotor     = 1'b0;
    rotor_init     = 5'd0;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
    bus.enc_ready  = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_char_ready", 32'(bus.char_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [4:0] rinit, input string s);
    tick(1'b1, rinit, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < s.len(); i++) tick(1'b0, 5'd0, 1'b1, s[i], 1'b1);
    idle(2);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] ch;
    do_reset();
    idle(2);

    send_word(5'd0, "ABC");
    check("flag_abc_r0", 32'(flag_bus), 32'h454341);
    check("rotor_abc_r0", 32'(rotor_out), 32'd3);
    check("flag_valid_abc", 32'(flag_valid), 32'd1);

    send_word(5'd24, "ABC");
    check("flag_abc_r24", 32'(flag_bus), 32'h434159);
    check("rotor_abc_r24", 32'(rotor_out), 32'd1);

    send_word(5'd0, "A3BC");
    check("flag_bad_skip", 32'(flag_bus), 32'h454341);

    send_word(5'd30, "ZZ");
    check("rotor_init_mod", 32'(rotor_out), 32'd6);

    // Downstream stall, then drain and accept in the same cycle.
    tick(1'b1, 5'd0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 5'd0, 1'b1, "A", 1'b0);
    tick(1'b0, 5'd0, 1'b1, "B", 1'b0);
    tick(1'b0, 5'd0, 1'b1, "B", 1'b0);
    tick(1'b0, 5'd0, 1'b1, "B", 1'b1);
    tick(1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
    check("stall_enc_c", 32'(bus.enc_out), 32'd67);
    idle(2);

    // Load wins over a simultaneous character, with a pending output kept.
    tick(1'b1, 5'd0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 5'd0, 1'b1, "A", 1'b0);
    tick(1'b1, 5'd7, 1'b1, "D", 1'b0);
    tick(1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
    check("load_prio_rotor", 32'(rotor_out), 32'd7);
    idle(2);

    // Reset in the middle of a word.
    tick(1'b1, 5'd3, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 5'd0, 1'b1, "H", 1'b1);
    tick(1'b0, 5'd0, 1'b1, "I", 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 5'd0, 1'b1, "Q", 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) ch = 8'(65 + $urandom_range(0, 25));
      else                          ch = 8'($urandom_range(0, 255));
      tick(($urandom_range(0, 19) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0), ch, ($urandom_range(0, 9) < 7));
    end

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
